cmp_result_fifo: RTL and testbench
==================================

Name: cmp_result_fifo

Overview:
- Downstream stage of the 4-bit comparator top module.
- Captures each comparator result (Out_Bits plus the Out_C flag) into a small synchronous FIFO, so a slower consumer can drain the results with a valid/ready handshake.
- Keeps a saturating count of accepted results whose flag is set, plus a sticky overflow indicator for results dropped while the FIFO is full.

Parameters:
- DATA_W, 4: width of the captured result bits (matches the comparator Out_Bits).
- DEPTH, 4: number of FIFO entries; must be a power of two, at least 2.
- CNT_W, 8: width of FLAG_COUNT and DROP_COUNT.

Ports:
- CLK  in  1  rising-edge clock, shared with the comparator.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  a comparator result is present this cycle (the comparator EN, delayed to line up with its registered outputs).
- IN_BITS  in  DATA_W  comparator Out_Bits.
- IN_FLAG  in  1  comparator Out_C.
- IN_READY  out  1  FIFO can accept; equals not-full.
- OUT_VALID  out  1  head entry available; equals not-empty.
- OUT_BITS  out  DATA_W  head entry result bits.
- OUT_FLAG  out  1  head entry flag.
- OUT_READY  in  1  consumer accepts the head entry.
- LEVEL  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- FLAG_COUNT  out  CNT_W  accepted entries with IN_FLAG=1, saturating.
- DROP_COUNT  out  CNT_W  results dropped while full, saturating.
- OVERFLOW  out  1  sticky; set on the first drop.
- CLR  in  1  synchronous clear of FLAG_COUNT, DROP_COUNT and OVERFLOW only.

Behaviour:
- Reset (RST=1, asynchronous):
  - Read/write pointers, LEVEL, FLAG_COUNT, DROP_COUNT and OVERFLOW go to 0.
  - OUT_VALID=0 and IN_READY=1.
  - OUT_BITS and OUT_FLAG read 0, because storage is cleared on reset.
  - Reset mid-transfer discards all stored entries; nothing is replayed.
- Storage and pointers:
  - DEPTH x (DATA_W+1) register array.
  - Write and read pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*DEPTH.
  - full = (the addresses are equal and the MSBs differ); empty = (the pointers are equal).
- Push: when IN_VALID && IN_READY at a CLK edge, {IN_FLAG, IN_BITS} is written at the write pointer and the write pointer increments.
- Pop: when OUT_VALID && OUT_READY at a CLK edge, the read pointer increments.
- Output data: OUT_BITS and OUT_FLAG are read combinationally at the read pointer. They are meaningful only while OUT_VALID=1.
- Latency: a push into an empty FIFO makes OUT_VALID=1 in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Neither empty nor full: both occur and LEVEL is unchanged.
  - Full: the pop occurs and the push is rejected. IN_READY is derived from the registered full only, with no pop-through, so the input is treated as a drop.
  - Empty: only the push can occur, because OUT_VALID=0.
- Drop: IN_VALID && !IN_READY is a drop.
  - DROP_COUNT increments, saturating at 2^CNT_W-1.
  - OVERFLOW is set to 1.
  - FIFO contents are unchanged.
- FLAG_COUNT: increments on every accepted push with IN_FLAG=1, saturating at 2^CNT_W-1. Dropped results are not counted.
- CLR:
  - On a CLK edge with CLR=1, the counters and OVERFLOW become 0.
  - CLR has priority over an increment in the same cycle; that event is lost.
  - FIFO contents and pointers are unaffected.
- LEVEL: equals wr_ptr - rd_ptr (modulo 2*DEPTH) and is registered consistently with the pointers.
- Handshake rules the consumer may rely on:
  - OUT_VALID never drops without a pop or RST.
  - The head data is stable while OUT_VALID=1 and OUT_READY=0.

Decomposition:
- Shared package cmp_pkg holds:
  - the constant CMP_DATA_W=4, shared with the comparator;
  - a localparam function clog2, used for pointer and LEVEL widths;
  - the result-record layout constants (flag bit index = DATA_W).
- One sub-module is natural: sat_counter (parameter W; ports CLK, RST, CLR, INC, Q). It is instantiated twice, for FLAG_COUNT and DROP_COUNT.

Test Plan:
- Reset release: assert RST for 3 cycles, then release -> OUT_VALID=0, IN_READY=1, LEVEL=0, FLAG_COUNT=0, OVERFLOW=0.
- Single pass-through: push {flag=1, bits=0011} with OUT_READY=0 -> next cycle OUT_VALID=1, OUT_BITS=0011, OUT_FLAG=1, LEVEL=1, FLAG_COUNT=1. Raise OUT_READY for one cycle -> LEVEL=0, OUT_VALID=0.
- Fill and overflow: push 0001, 0010, 0011, 0100 with flags 0,1,0,1, then push 0101 -> LEVEL=4, IN_READY=0, DROP_COUNT=1, OVERFLOW=1, FLAG_COUNT=2. Drain 4 entries -> data pops out in order 0001..0100.
- Simultaneous push/pop at LEVEL=2: push 0111 while popping for 3 consecutive cycles -> LEVEL stays 2 throughout and output order is preserved. Also push while full and popping -> push rejected and DROP_COUNT increments.
- Wrap-around: run 10 push/pop pairs through DEPTH=4 with bits 0..9 mod 16 -> every value comes out in order, with no spurious full or empty.
- CLR and saturation: set CNT_W=2 and accept 5 flagged results (popping to avoid drops) -> FLAG_COUNT=3. Pulse CLR together with a flagged push -> FLAG_COUNT=0, OVERFLOW=0, and LEVEL unchanged by the CLR.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants and helpers for the comparator and its result FIFO.
package cmp_pkg;

  // Width of the comparator Out_Bits.
  localparam int CMP_DATA_W = 4;

  // A stored result record is {flag, bits}; the flag sits just above the bits.
  localparam int CMP_FLAG_IDX = CMP_DATA_W;

  // Ceiling log2, usable in constant expressions such as port widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cmp_result_fifo_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_q, q_d;

  // Next count: clear first, otherwise step unless already at all-ones.
  always_comb begin
    q_d = q_q;
    if (CLR)                q_d = '0;
    else if (INC && ~&q_q)  q_d = q_q + W'(1);
  end

  // Count register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/cmp_result_fifo.sv
// Result FIFO behind the comparator: buffers {flag, bits} records for a
// slower valid/ready consumer, counts flagged results and dropped results.
module cmp_result_fifo
  import cmp_pkg::*;
#(
  parameter int DATA_W = CMP_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  input  logic [DATA_W-1:0]       IN_BITS,
  input  logic                    IN_FLAG,
  output logic                    IN_READY,
  output logic                    OUT_VALID,
  output logic [DATA_W-1:0]       OUT_BITS,
  output logic                    OUT_FLAG,
  input  logic                    OUT_READY,
  output logic [clog2(DEPTH):0]   LEVEL,
  output logic [CNT_W-1:0]        FLAG_COUNT,
  output logic [CNT_W-1:0]        DROP_COUNT,
  output logic                    OVERFLOW,
  input  logic                    CLR
);

  localparam int AW       = clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam int FLAG_IDX = DATA_W;

  logic [DEPTH-1:0][DATA_W:0] mem_q;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              level_q;
  logic                       ovf_q, ovf_d;
  logic                       full, empty, push, pop, drop;
  logic [DATA_W:0]            head;

  // Extra pointer MSB separates a full ring from an empty one.
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready comes from registered state only, so a pop never frees a slot for
  // a push in the same cycle; input arriving while full is dropped.
  assign push = IN_VALID && !full;
  assign pop  = !empty && OUT_READY;
  assign drop = IN_VALID && full;

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Sticky overflow, cleared by CLR with priority over a new drop.
  always_comb begin
    ovf_d = ovf_q;
    if (CLR)       ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= wr_ptr_d - rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; cleared on reset so the head reads zero after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {IN_FLAG, IN_BITS};
    end
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign OUT_BITS  = head[DATA_W-1:0];
  assign OUT_FLAG  = head[FLAG_IDX];
  assign OUT_VALID = !empty;
  assign IN_READY  = !full;
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;

  sat_counter #(.W(CNT_W)) u_flag_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (push && IN_FLAG),
    .Q   (FLAG_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (drop),
    .Q   (DROP_COUNT)
  );

endmodule

// File: tb/tb_cmp_result_fifo.sv
// Bench for cmp_result_fifo: behavioural occupancy/counter model plus a data
// scoreboard, a vector table for the fill/overflow/drain run, and hand
// sequences for concurrency, wrap, CLR/saturation and reset mid-transfer.
module tb_cmp_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID, IN_FLAG, IN_READY;
  logic [3:0] IN_BITS;
  logic       OUT_VALID, OUT_FLAG, OUT_READY;
  logic [3:0] OUT_BITS;
  logic [2:0] LEVEL;
  logic [CNT_W-1:0] FLAG_COUNT, DROP_COUNT;
  logic       OVERFLOW, CLR;

  cmp_result_fifo #(.DATA_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_BITS(IN_BITS),
    .IN_FLAG(IN_FLAG), .IN_READY(IN_READY), .OUT_VALID(OUT_VALID),
    .OUT_BITS(OUT_BITS), .OUT_FLAG(OUT_FLAG), .OUT_READY(OUT_READY),
    .LEVEL(LEVEL), .FLAG_COUNT(FLAG_COUNT), .DROP_COUNT(DROP_COUNT),
    .OVERFLOW(OVERFLOW), .CLR(CLR)
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntotal = 0;

  // Reference state.
  logic [4:0] sb[$];
  int m_lvl, m_fc, m_dc;
  bit m_ovf;

  typedef struct {
    bit v; bit [3:0] b; bit f; bit r; bit c;
    int lvl; int fc; int dc; bit ovf;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock of stimulus: drive at negedge, check popped data before the
  // edge, update the model, check state just after the edge.
  task automatic step(input bit v, input bit [3:0] b, input bit f,
                      input bit r, input bit c);
    bit acc, mpop;
    logic [4:0] e;
    @(negedge CLK);
    IN_VALID = v; IN_BITS = b; IN_FLAG = f; OUT_READY = r; CLR = c;
    #1;
    acc  = v && (m_lvl < DEPTH);
    mpop = r && (m_lvl > 0);
    if (mpop) begin
      e = sb.pop_front();
      chk("pop_bits", int'(OUT_BITS), int'(e[3:0]));
      chk("pop_flag", int'(OUT_FLAG), int'(e[4]));
    end
    if (acc) sb.push_back({f, b});
    m_lvl = m_lvl + int'(acc) - int'(mpop);
    if (c) begin
      m_fc = 0; m_dc = 0; m_ovf = 0;
    end else begin
      if (acc && f && m_fc < CMAX) m_fc++;
      if (v && !acc) begin
        if (m_dc < CMAX) m_dc++;
        m_ovf = 1;
      end
    end
    @(posedge CLK);
    #1;
    chk("level",      int'(LEVEL),      m_lvl);
    chk("in_ready",   int'(IN_READY),   int'(m_lvl < DEPTH));
    chk("out_valid",  int'(OUT_VALID),  int'(m_lvl > 0));
    chk("flag_count", int'(FLAG_COUNT), m_fc);
    chk("drop_count", int'(DROP_COUNT), m_dc);
    chk("overflow",   int'(OVERFLOW),   int'(m_ovf));
  endtask

  task automatic idle();
    step(0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    // Fill/overflow/drain table with hand-derived expectations.
    //          v  b      f  r  c  lvl fc dc ovf
    tbl[0] = '{0, 4'h0, 0, 0, 1, 0,  0, 0, 0};
    tbl[1] = '{1, 4'h1, 0, 0, 0, 1,  0, 0, 0};
    tbl[2] = '{1, 4'h2, 1, 0, 0, 2,  1, 0, 0};
    tbl[3] = '{1, 4'h3, 0, 0, 0, 3,  1, 0, 0};
    tbl[4] = '{1, 4'h4, 1, 0, 0, 4,  2, 0, 0};
    tbl[5] = '{1, 4'h5, 0, 0, 0, 4,  2, 1, 1};
    tbl[6] = '{0, 4'h0, 0, 1, 0, 3,  2, 1, 1};
    tbl[7] = '{0, 4'h0, 0, 1, 0, 2,  2, 1, 1};
    tbl[8] = '{0, 4'h0, 0, 1, 0, 1,  2, 1, 1};
    tbl[9] = '{0, 4'h0, 0, 1, 0, 0,  2, 1, 1};

    IN_VALID = 0; IN_BITS = 0; IN_FLAG = 0; OUT_READY = 0; CLR = 0;
    m_lvl = 0; m_fc = 0; m_dc = 0; m_ovf = 0;

    // Reset release.
    RST = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    #1;
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_in_ready",  int'(IN_READY),  1);
    chk("rst_level",     int'(LEVEL),     0);
    chk("rst_flag_cnt",  int'(FLAG_COUNT), 0);
    chk("rst_drop_cnt",  int'(DROP_COUNT), 0);
    chk("rst_overflow",  int'(OVERFLOW),  0);
    chk("rst_out_bits",  int'(OUT_BITS),  0);
    chk("rst_out_flag",  int'(OUT_FLAG),  0);

    // Single pass-through.
    step(1, 4'b0011, 1, 0, 0);
    chk("pt_bits", int'(OUT_BITS), 3);
    chk("pt_flag", int'(OUT_FLAG), 1);
    chk("pt_fc",   int'(FLAG_COUNT), 1);
    step(0, 4'h0, 0, 1, 0);
    chk("pt_drained", int'(OUT_VALID), 0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].f, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), int'(LEVEL),      tbl[i].lvl);
      chk($sformatf("tbl%0d_fc", i),    int'(FLAG_COUNT), tbl[i].fc);
      chk($sformatf("tbl%0d_dc", i),    int'(DROP_COUNT), tbl[i].dc);
      chk($sformatf("tbl%0d_ovf", i),   int'(OVERFLOW),   int'(tbl[i].ovf));
    end

    // Simultaneous push/pop at level 2, then push while full and popping.
    step(1, 4'h8, 0, 0, 0);
    step(1, 4'h9, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h7, 0, 1, 0);
      chk("pp_level2", int'(LEVEL), 2);
    end
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'hB, 0, 0, 0);
    step(1, 4'hC, 0, 1, 0);
    chk("full_pop_level", int'(LEVEL), 3);
    chk("full_pop_drop",  int'(DROP_COUNT), 2);
    repeat (3) step(0, 4'h0, 0, 1, 0);

    // Wrap-around: ten push/pop pairs.
    for (int i = 0; i < 10; i++) begin
      step(1, 4'(i), i[0], 0, 0);
      chk("wrap_valid", int'(OUT_VALID), 1);
      step(0, 4'h0, 0, 1, 0);
      chk("wrap_empty", int'(OUT_VALID), 0);
    end

    // CLR then flag-count saturation with pops to avoid drops.
    step(0, 4'h0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 1, 1, 0);
    chk("fc_sat", int'(FLAG_COUNT), 3);
    repeat (3) step(1, 4'hE, 0, 0, 0);
    repeat (4) step(1, 4'hF, 0, 0, 0);
    chk("dc_sat", int'(DROP_COUNT), 3);
    step(0, 4'h0, 0, 1, 0);
    step(1, 4'h6, 1, 0, 1);
    chk("clr_fc",    int'(FLAG_COUNT), 0);
    chk("clr_dc",    int'(DROP_COUNT), 0);
    chk("clr_ovf",   int'(OVERFLOW),   0);
    chk("clr_level", int'(LEVEL),      4);
    repeat (4) step(0, 4'h0, 0, 1, 0);

    // Reset mid-transfer discards contents.
    step(1, 4'h3, 1, 0, 0);
    step(1, 4'h4, 0, 0, 0);
    @(negedge CLK);
    IN_VALID = 0; OUT_READY = 0;
    RST = 1;
    #2;
    chk("mid_rst_valid", int'(OUT_VALID), 0);
    chk("mid_rst_level", int'(LEVEL), 0);
    chk("mid_rst_fc",    int'(FLAG_COUNT), 0);
    @(negedge CLK);
    RST = 0;
    sb.delete();
    m_lvl = 0; m_fc = 0; m_dc = 0; m_ovf = 0;
    step(0, 4'h0, 0, 1, 0);
    idle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
